gfx_rom_arbiter: RTL and testbench

- Shares one graphics-ROM SDRAM channel between several toggle-handshake requesters: TC0100SCN BG0/BG1 fetches, sprite engine, spare.
- Each requester sees a private ROM port with toggle req/ack semantics, identical to the tilemap chip's rom_req/rom_ack.
- Round-robin arbitration; one outstanding SDRAM transaction at a time.
- Sits between the video chips and the SDRAM controller's ROM channel.

---
 rtl/gfx_rom_arb_pkg.sv | 6 +
 rtl/gfx_rom_arb_rr_pick.sv | 21 ++
 rtl/gfx_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_rom_arb_pkg.sv
// gfx_rom_arb_pkg: shared FSM states, port index type and limits for the graphics-ROM arbiter.
package gfx_rom_arb_pkg;
    localparam int MAX_PORTS = 8;
    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_WAIT} state_t;
    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/gfx_rom_arb_rr_pick.sv
// gfx_rom_arb_rr_pick: round-robin winner select, first pending port at or after rr_ptr.
module gfx_rom_arb_rr_pick
    import gfx_rom_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  port_idx_t            rr_ptr,
    output logic                 any,
    output port_idx_t            winner
);
    logic [2*NUM_PORTS-1:0] rot;
    // Doubling the vector lets a plain shift stand in for a rotate.
    always_comb begin
        rot = {pending, pending} >> rr_ptr;
        winner = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--)
            if (rot[i]) winner = port_idx_t'((int'(rr_ptr) + i) % NUM_PORTS);
    end
    assign any = |pending;
endmodule

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one toggle-handshake SDRAM ROM channel among NUM_PORTS requesters.
// Define GFX_ROM_ARB_CACHE_EN to add a per-port last-address hit cache.
module gfx_rom_arbiter
    import gfx_rom_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]            req_toggle,
    output logic [NUM_PORTS-1:0]            ack_toggle,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic                            cache_flush,
    output logic [ADDR_WIDTH-1:0]           sdr_addr,
    output logic                            sdr_req,
    input  logic                            sdr_ack,
    input  logic [DATA_WIDTH-1:0]           sdr_data,
    output logic                            busy
);
    state_t state, state_n;
    port_idx_t rr_ptr, gnt_idx, winner, base, next_ptr;
    logic any, hit, take_hit, grant, done, ack_match;
    logic [NUM_PORTS-1:0] pending, gsel, wsel, ack_flip;
    logic [ADDR_WIDTH-1:0] win_addr;

    assign pending   = req_toggle ^ ack_toggle;
    assign ack_match = sdr_ack == sdr_req;
    assign busy      = state == S_WAIT;

    gfx_rom_arb_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .pending(pending),
        .rr_ptr(rr_ptr),
        .any(any),
        .winner(winner)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gsel[i] = gnt_idx == port_idx_t'(i);
            wsel[i] = winner == port_idx_t'(i);
            if (wsel[i]) win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

`ifdef GFX_ROM_ARB_CACHE_EN
    logic [NUM_PORTS-1:0] valid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] win_last;
    always_comb begin
        win_last = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (wsel[i]) win_last = last_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    // A flush in the same cycle as the lookup must not be bypassed by a stale hit.
    assign hit = |(valid & wsel) && !cache_flush && win_last == win_addr;
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            last_addr <= '0;
        end else begin
            valid <= (valid | (done ? gsel : '0)) & {NUM_PORTS{!cache_flush}};
            for (int i = 0; i < NUM_PORTS; i++)
                if (done && gsel[i]) last_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= sdr_addr;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = cache_flush;
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        grant = 1'b0;
        done = 1'b0;
        take_hit = 1'b0;
        case (state)
            S_RESYNC: state_n = ack_match ? S_IDLE : S_RESYNC;
            S_IDLE: begin
                take_hit = any && hit;
                grant = any && !hit;
                state_n = grant ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                done = ack_match;
                state_n = done ? S_IDLE : S_WAIT;
            end
            default: state_n = S_RESYNC;
        endcase
    end

    assign base     = done ? gnt_idx : winner;
    assign next_ptr = int'(base) == NUM_PORTS-1 ? '0 : base + 1'b1;
    assign ack_flip = done ? gsel : take_hit ? wsel : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESYNC;
            rr_ptr <= '0;
            gnt_idx <= '0;
            sdr_addr <= '0;
            sdr_req <= 1'b0;
            ack_toggle <= '0;
            req_data <= '0;
        end else begin
            state <= state_n;
            ack_toggle <= ack_toggle ^ ack_flip;
            if (done || take_hit) rr_ptr <= next_ptr;
            if (grant) begin
                gnt_idx <= winner;
                sdr_addr <= win_addr;
                sdr_req <= ~sdr_req;
            end
            for (int i = 0; i < NUM_PORTS; i++)
                if (done && gsel[i]) req_data[i*DATA_WIDTH +: DATA_WIDTH] <= sdr_data;
        end
    end
endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// tb_gfx_rom_arbiter: directed stimulus, downstream SDRAM model and per-cycle reference model.
module tb_gfx_rom_arbiter;
    localparam int N = 4, AW = 21, DW = 32;

    logic clk = 1'b0, reset = 1'b1, cache_flush = 1'b0, sdr_ack = 1'b1;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0] req_toggle = '0, ack_toggle;
    logic [N*DW-1:0] req_data;
    logic [AW-1:0] sdr_addr;
    logic sdr_req, busy;
    logic [DW-1:0] sdr_data = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    gfx_rom_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_toggle(req_toggle),
        .ack_toggle(ack_toggle), .req_data(req_data), .cache_flush(cache_flush),
        .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return a == 21'h12344 ? 32'hDEADBEEF : {11'h5A5, a};
    endfunction

    // Downstream SDRAM: answers each new sdr_req toggle after ds_lat cycles.
    logic ds_auto = 1'b0, ds_seen = 1'b0;
    int ds_lat = 5, ds_cnt = 0;
    logic [AW-1:0] ds_addr = '0;
    always @(posedge clk) begin
        #1;
        if (ds_auto) begin
            if (sdr_req !== ds_seen) begin
                ds_seen = sdr_req;
                ds_cnt = ds_lat;
                ds_addr = sdr_addr;
            end else if (ds_cnt > 0) begin
                ds_cnt--;
                if (ds_cnt == 0) begin
                    sdr_data = mem(ds_addr);
                    sdr_ack = ds_seen;
                end
            end
        end
    end

    // Reference model: applies the inputs captured one negedge earlier, then compares.
    int m_ph = 0, m_ptr = 0, m_gnt = 0;
    logic m_sreq = 1'b0;
    logic [AW-1:0] m_saddr = '0;
    logic [N-1:0] m_ack = '0, m_valid = '0;
    logic [DW-1:0] m_data [N];
    logic [AW-1:0] m_last [N];
    logic p_reset = 1'b1, p_sack = 1'b1, p_flush = 1'b0;
    logic [N-1:0] p_req = '0;
    logic [N*AW-1:0] p_addr = '0;
    logic [DW-1:0] p_sdata = '0;
    logic [AW-1:0] gq [$];
    logic last_sreq = 1'b0;

    always @(negedge clk) begin
        int w;
        logic hit;
        logic [N-1:0] pend;
        pend = p_req ^ m_ack;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`ifdef GFX_ROM_ARB_CACHE_EN
        hit = w >= 0 && m_valid[w] && !p_flush && m_last[w] == p_addr[w*AW +: AW];
`else
        hit = 1'b0;
`endif
        if (p_reset) begin
            m_ph = 0; m_ptr = 0; m_gnt = 0; m_sreq = 1'b0; m_saddr = '0; m_ack = '0; m_valid = '0;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else if (m_ph == 0) begin
            if (p_sack == m_sreq) m_ph = 1;
        end else if (m_ph == 1) begin
            if (w >= 0 && hit) begin
                m_ack[w] = ~m_ack[w];
                m_ptr = (w + 1) % N;
            end else if (w >= 0) begin
                m_gnt = w;
                m_saddr = p_addr[w*AW +: AW];
                m_sreq = ~m_sreq;
                m_ph = 2;
            end
        end else if (p_sack == m_sreq) begin
            m_data[m_gnt] = p_sdata;
            m_ack[m_gnt] = ~m_ack[m_gnt];
            m_ptr = (m_gnt + 1) % N;
            m_valid[m_gnt] = 1'b1;
            m_last[m_gnt] = m_saddr;
            m_ph = 1;
        end
        if (p_flush) m_valid = '0;
        chk("ack_toggle", ack_toggle, m_ack);
        chk("sdr_req", sdr_req, m_sreq);
        chk("sdr_addr", sdr_addr, m_saddr);
        chk("busy", busy, m_ph == 2);
        for (int i = 0; i < N; i++) chk("req_data", req_data[i*DW +: DW], m_data[i]);
        if (sdr_req !== last_sreq && busy) gq.push_back(sdr_addr);
        last_sreq = sdr_req;
        p_reset = reset; p_req = req_toggle; p_addr = req_addr;
        p_sack = sdr_ack; p_sdata = sdr_data; p_flush = cache_flush;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic [AW-1:0] a);
        req_addr[p*AW +: AW] = a;
        req_toggle[p] = ~req_toggle[p];
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && ack_toggle !== req_toggle; c++) tick();
        chk("drain", ack_toggle, req_toggle);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_toggle = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pos;
        tick(2);
        chk("rst_ack", ack_toggle, 0);
        chk("rst_data_lo", req_data[63:0], 0);
        chk("rst_data_hi", req_data[127:64], 0);
        chk("rst_sreq", sdr_req, 0);
        chk("rst_saddr", sdr_addr, 0);
        reset = 1'b0;
        req(2, 21'h01A40);
        tick(5);
        chk("resync_hold_sreq", sdr_req, 0);
        chk("resync_hold_busy", busy, 0);
        sdr_ack = 1'b0;
        ds_seen = 1'b0;
        ds_auto = 1'b1;
        tick(2);
        chk("t1_sreq", sdr_req, 1);
        chk("t1_saddr", sdr_addr, 21'h01A40);
        wait_idle();
        chk("t1_data2", req_data[2*DW +: DW], mem(21'h01A40));

        req(1, 21'h12344);
        wait_idle();
        chk("t2_data1", req_data[DW +: DW], 32'hDEADBEEF);
        chk("t2_acks", ack_toggle, 4'b0110);
        chk("t2_data0", req_data[0 +: DW], 0);
        chk("t2_data3", req_data[3*DW +: DW], 0);
        chk("t2_data2", req_data[2*DW +: DW], mem(21'h01A40));

        do_reset();
        tick(2);
        gq.delete();
        for (int p = 0; p < N; p++) req(p, 21'h00200 + 21'(p));
        wait_idle();
        chk("t3_count", gq.size(), 4);
        for (int p = 0; p < N && p < gq.size(); p++) chk("t3_order", gq[p], 21'h00200 + 21'(p));
        gq.delete();
        req(3, 21'h00303);
        req(0, 21'h00300);
        wait_idle();
        chk("t3_count2", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("t3_wrap_first", gq[0], 21'h00300);
            chk("t3_wrap_second", gq[1], 21'h00303);
        end

        if (sdr_req == 1'b0) begin
            req(2, 21'h00402);
            wait_idle();
        end
        ds_lat = 20;
        req(1, 21'h00401);
        tick(3);
        chk("t4_busy", busy, 1);
        do_reset();
        chk("t4_rst_ack", ack_toggle, 0);
        chk("t4_rst_data", req_data[63:0], 0);
        ds_lat = 5;
        req(0, 21'h00400);
        tick(3);
        chk("t4_resync_sreq", sdr_req, 0);
        chk("t4_resync_busy", busy, 0);
        wait_idle();
        chk("t4_data0", req_data[0 +: DW], mem(21'h00400));
        chk("t4_stale_data1", req_data[DW +: DW], 0);

`ifdef GFX_ROM_ARB_CACHE_EN
        gq.delete();
        req(0, 21'h00100);
        wait_idle();
        req(0, 21'h00100);
        tick();
        chk("t5_hit_ack", ack_toggle[0], req_toggle[0]);
        chk("t5_one_sdr", gq.size(), 1);
        cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        req(0, 21'h00100);
        wait_idle();
        chk("t5_flush_miss", gq.size(), 2);
`endif

        gq.delete();
        req(3, 21'h00633);
        pos = -1;
        for (int c = 0; c < 400 && pos < 0; c++) begin
            for (int p = 0; p < 3; p++)
                if (ack_toggle[p] == req_toggle[p]) req(p, 21'h00600 + 21'(c*4 + p));
            tick();
            foreach (gq[i]) if (pos < 0 && gq[i] == 21'h00633) pos = i;
        end
        chk("t6_p3_within_4", pos >= 0 && pos < 4, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
